tow_referee: RTL

//  Round referee for the tug-of-war game. Watches the two player pushbuttons

---
 rtl/tow_referee.sv | 130 +++++++++++++
 1 files changed

// File: rtl/tow_referee.sv
// tow_referee: round referee for the tug-of-war game.
// Detects the first valid button press of each round, moves the rope position
// one LED step towards the winner, pulses winrnd to the master controller and
// latches the game winner once the rope reaches either end.
// Optional build macro: TOW_FALSE_START_EN. When it is defined, a press made
// before the go-stimulus awards the point to the opponent.
//
// Round handshake with the master controller: clear (1-cycle pulse) arms a new
// round; winrnd (1-cycle pulse, registered, one cycle after the deciding press)
// reports that the round is decided; no second winrnd is issued until the next
// clear has been accepted.
module tow_referee #(
  parameter int HALF  = 4,
  parameter int POS_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pbl,
  input  logic             pbr,
  input  logic             clear,
  input  logic             leds_on,
  output logic             winrnd,
  output logic [POS_W-1:0] pos,
  output logic             game_over,
  output logic [1:0]       winner
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_GO     = 2'd1,
    S_SCORED = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  localparam logic [POS_W-1:0] POS_CTR = POS_W'(HALF);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(2 * HALF);

  state_t           state;
  logic             pbl_q;
  logic             pbr_q;
  logic             press_l;
  logic             press_r;
  logic             scored;
  logic             score_up;
  logic             score_dn;
  logic [POS_W-1:0] pos_next;

  assign press_l = pbl & ~pbl_q;
  assign press_r = pbr & ~pbr_q;

  // Decide whether this cycle settles the round and which way the rope moves.
  always_comb begin
    scored   = 1'b0;
    score_up = 1'b0;
    score_dn = 1'b0;
    case (state)
      S_GO: begin
        // clear aborts the round and swallows any press in the same cycle
        if (!clear) begin
          scored   = press_l | press_r;
          score_up = press_r & ~press_l;
          score_dn = press_l & ~press_r;
        end
      end
`ifdef TOW_FALSE_START_EN
      S_WAIT: begin
        // a lone early press gives the point to the other player
        if (!clear && !leds_on && (press_l ^ press_r)) begin
          scored   = 1'b1;
          score_up = press_l;
          score_dn = press_r;
        end
      end
`else
      S_WAIT: ;
`endif
      default: ;
    endcase

    pos_next = pos;
    if (score_up && (pos != POS_MAX)) begin
      pos_next = pos + 1'b1;
    end else if (score_dn && (pos != '0)) begin
      pos_next = pos - 1'b1;
    end
  end

  // Round FSM with registered outputs and button edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_WAIT;
      pos       <= POS_CTR;
      winrnd    <= 1'b0;
      game_over <= 1'b0;
      winner    <= 2'b00;
      // start high so a button held through reset does not look like a press
      pbl_q     <= 1'b1;
      pbr_q     <= 1'b1;
    end else begin
      pbl_q  <= pbl;
      pbr_q  <= pbr;
      winrnd <= 1'b0;
      if (state == S_OVER) begin
        state <= S_OVER;
      end else if (scored) begin
        winrnd <= 1'b1;
        pos    <= pos_next;
        if (pos_next == '0) begin
          state     <= S_OVER;
          game_over <= 1'b1;
          winner    <= 2'b01;
        end else if (pos_next == POS_MAX) begin
          state     <= S_OVER;
          game_over <= 1'b1;
          winner    <= 2'b10;
        end else begin
          state <= S_SCORED;
        end
      end else begin
        case (state)
          S_WAIT:   if (!clear && leds_on) state <= S_GO;
          S_GO:     if (clear) state <= S_WAIT;
          S_SCORED: if (clear) state <= S_WAIT;
          default:  state <= state;
        endcase
      end
    end
  end

endmodule
